pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and flush controller for the pipelined core.
- Replaces the fixed two-source forwarding mux and stall-only hazard check with four features:
  - a register scoreboard for variable-latency (AXI4-Lite) loads;
  - N forwarding stages with a load-return bypass;
  - a multi-cycle branch flush;
  - an outstanding-load limit and a stall performance counter.
- Sits between the ID stage (register file, control) and the EX stage operand inputs.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, number of architectural registers; register index width RW = clog2(NREG).
- FWD_STAGES, 2, number of forwarding sources. Index 0 is the youngest (EX/MEM); higher indices are older.
- FLUSH_DEPTH, 2, number of cycles flush is asserted per redirect (>=1).
- MAX_LOADS, 4, maximum outstanding loads (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- id_valid  in  1  ID holds a valid instruction
- id_rs1, id_rs2  in  RW  source register indices
- id_use_rs1, id_use_rs2  in  1  source is actually read
- id_rd  in  RW  destination register index
- id_regwrite  in  1  instruction writes id_rd
- id_is_load  in  1  instruction is a load
- rf_rs1data, rf_rs2data  in  XLEN  register file read data
- fwd_we  in  FWD_STAGES  per-stage write enable
- fwd_rd  in  FWD_STAGES*RW  per-stage destination index
- fwd_data  in  FWD_STAGES*XLEN  per-stage result
- ld_done  in  1  load data returned this cycle
- ld_rd  in  RW  destination of the returning load
- ld_data  in  XLEN  returning load data
- redirect  in  1  taken branch/jump resolved in EX
- id_issue  out  1  ID instruction advances to EX this cycle
- hold_pc  out  1  freeze PC and IF/ID
- flush  out  1  squash IF/ID and ID/EX
- rs1_fwd, rs2_fwd  out  XLEN  resolved operands to EX
- rs1_sel, rs2_sel  out  FWD_STAGES+2  one-hot source selector: bits 0..N-1 = fwd stage, bit N = ld bypass, bit N+1 = register file
- sb_pending  out  NREG  scoreboard (bit i = load pending to register i)
- ld_err  out  1  sticky: ld_done arrived with no outstanding load
- stall_count  out  32  cycles with hold_pc=1, saturating

Behaviour:
Clocking and reset:
- All state updates on the rising edge of clk. Reset is synchronous and active-high (rst=1 at the clk edge).
- Reset values: sb_pending=0, outstanding count=0, flush counter=0, ld_err=0, stall_count=0.
- The remaining outputs are combinational. With id_valid=0 they settle to id_issue=0, hold_pc=0 and flush=redirect.

Operand resolution (combinational):
- Index 0 or unused source: rsX_fwd = rf data, sel = RF bit.
- Otherwise the first match in this order wins:
  1. fwd stage k (lowest k first) with fwd_we[k] and fwd_rd[k]==src;
  2. ld_done with ld_rd==src;
  3. register file.
- A stale fwd stage whose rd equals a pending register cannot occur, because of the WAW stall below.

Stall and issue:
- src_hazard(X) = use_X, src!=0, sb_pending[src]=1, and not (ld_done and ld_rd==src).
- waw = id_regwrite, id_rd!=0, sb_pending[id_rd]=1, and not (ld_done and ld_rd==id_rd).
- ldfull = id_is_load and count==MAX_LOADS and not ld_done.
- stall = id_valid and (src_hazard(rs1) or src_hazard(rs2) or waw or ldfull).
- flush = redirect or flush_cnt!=0.
- hold_pc = stall and not flush (flush overrides stall).
- id_issue = id_valid and not stall and not flush.

Scoreboard:
- Set on id_issue, id_is_load, id_rd!=0: bit id_rd set.
- Clear on ld_done: bit ld_rd cleared.
- Set and clear of the same bit in the same cycle: set wins.
- Loads targeting x0 still count as outstanding.

Outstanding count:
- +1 when a load issues; -1 on ld_done; both in the same cycle leaves it unchanged.
- ld_done with count==0 (and no load issuing that cycle): count stays 0, ld_err set until rst.

Flush counter:
- On redirect, flush_cnt loads FLUSH_DEPTH-1. Otherwise it decrements toward 0.
- A redirect during an active flush reloads the counter.
- Loads already issued are not cancelled; the scoreboard and count are unaffected by flush.

stall_count:
- Increments when hold_pc=1; saturates at 0xFFFFFFFF.

Test Plan:
1. Reset, then ID add x3=x1+x2 while fwd_we[0]=1, fwd_rd[0]=1, fwd_data[0]=0x55, and fwd_we[1]=1, fwd_rd[1]=1, fwd_data[1]=0x77 -> rs1_fwd=0x55, rs1_sel bit0, rs2 from RF, id_issue=1.
2. Issue lw x5, then ID reads x5 for 3 cycles with no ld_done -> hold_pc=1, id_issue=0, sb_pending[5]=1, stall_count=3. Then ld_done with ld_rd=5, ld_data=0xDEAD -> same cycle id_issue=1, rs1_fwd=0xDEAD, rs1_sel bit N; next cycle sb_pending[5]=0.
3. Issue MAX_LOADS=4 loads to x6..x9, then a 5th load -> stalls (ldfull). Raise ld_done for x6 in that cycle -> 5th load issues and the count stays 4.
4. redirect pulse for 1 cycle with FLUSH_DEPTH=2 -> flush=1 for 2 cycles, id_issue=0, hold_pc=0 even while a source hazard exists. A second redirect in cycle 2 -> flush extends to 3 cycles total.
5. ld_done with no outstanding loads -> ld_err=1 and stays 1. Assert rst for 1 cycle -> all reset values restored, including ld_err=0 and stall_count=0.
6. Load to x4 pending, ID instruction writes x4 (no source use) -> waw stall. Same-cycle ld_done for x4 while a new load to x4 issues -> sb_pending[4] remains 1 (set wins).

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard, forwarding and flush control between ID and EX.
// Tracks outstanding variable-latency loads in a per-register scoreboard,
// resolves EX operands from N forwarding stages, a load-return bypass or the
// register file, and squashes IF/ID and ID/EX for a programmable number of
// cycles after a redirect.
module pipe_hazard_ctrl #(
  parameter int XLEN        = 32,
  parameter int NREG        = 32,
  parameter int FWD_STAGES  = 2,
  parameter int FLUSH_DEPTH = 2,
  parameter int MAX_LOADS   = 4,
  localparam int RW         = $clog2(NREG),
  localparam int SELW       = FWD_STAGES + 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [RW-1:0]              id_rs1,
  input  logic [RW-1:0]              id_rs2,
  input  logic                       id_use_rs1,
  input  logic                       id_use_rs2,
  input  logic [RW-1:0]              id_rd,
  input  logic                       id_regwrite,
  input  logic                       id_is_load,
  input  logic [XLEN-1:0]            rf_rs1data,
  input  logic [XLEN-1:0]            rf_rs2data,
  input  logic [FWD_STAGES-1:0]      fwd_we,
  input  logic [FWD_STAGES*RW-1:0]   fwd_rd,
  input  logic [FWD_STAGES*XLEN-1:0] fwd_data,
  input  logic                       ld_done,
  input  logic [RW-1:0]              ld_rd,
  input  logic [XLEN-1:0]            ld_data,
  input  logic                       redirect,
  output logic                       id_issue,
  output logic                       hold_pc,
  output logic                       flush,
  output logic [XLEN-1:0]            rs1_fwd,
  output logic [XLEN-1:0]            rs2_fwd,
  output logic [SELW-1:0]            rs1_sel,
  output logic [SELW-1:0]            rs2_sel,
  output logic [NREG-1:0]            sb_pending,
  output logic                       ld_err,
  output logic [31:0]                stall_count
);

  localparam int CW = $clog2(MAX_LOADS + 1);
  localparam int FW = $clog2(FLUSH_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX      = CW'(MAX_LOADS);
  localparam logic [CW-1:0] CNT_ZERO     = CW'(0);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [FW-1:0] FLUSH_RELOAD = FW'(FLUSH_DEPTH - 1);
  localparam logic [FW-1:0] FLUSH_ZERO   = FW'(0);
  localparam logic [FW-1:0] FLUSH_ONE    = FW'(1);
  localparam logic [RW-1:0] REG_ZERO     = RW'(0);

  logic [NREG-1:0] r_sb;
  logic [CW-1:0]   r_cnt;
  logic [FW-1:0]   r_flush_cnt;
  logic            r_ld_err;
  logic [31:0]     r_stall_cnt;

  logic [SELW+XLEN-1:0] w_rs1_res;
  logic [SELW+XLEN-1:0] w_rs2_res;
  logic                 w_haz1;
  logic                 w_haz2;
  logic                 w_waw;
  logic                 w_ldfull;
  logic                 w_stall;
  logic                 w_flush;
  logic                 w_issue;
  logic                 w_ld_issue;
  logic [NREG-1:0]      w_sb_next;

  // Operand source: youngest matching forwarding stage, then the returning
  // load, then the register file. x0 and unused sources always take the RF.
  function automatic logic [SELW+XLEN-1:0] f_resolve(
    input logic [RW-1:0]              src,
    input logic                       use_src,
    input logic [XLEN-1:0]            rf_data,
    input logic [FWD_STAGES-1:0]      we,
    input logic [FWD_STAGES*RW-1:0]   rd,
    input logic [FWD_STAGES*XLEN-1:0] data,
    input logic                       ldv,
    input logic [RW-1:0]              ldr,
    input logic [XLEN-1:0]            ldd
  );
    logic [SELW-1:0] sel;
    logic [XLEN-1:0] res;
    logic            hit;
    sel           = {SELW{1'b0}};
    sel[SELW-1]   = 1'b1;
    res           = rf_data;
    hit           = 1'b0;
    if (use_src && (src != REG_ZERO)) begin
      for (int k = 0; k < FWD_STAGES; k++) begin
        if (!hit && we[k] && (rd[k*RW +: RW] == src)) begin
          hit    = 1'b1;
          sel    = {SELW{1'b0}};
          sel[k] = 1'b1;
          res    = data[k*XLEN +: XLEN];
        end
      end
      if (!hit && ldv && (ldr == src)) begin
        sel             = {SELW{1'b0}};
        sel[FWD_STAGES] = 1'b1;
        res             = ldd;
      end
    end
    return {sel, res};
  endfunction

  // A register is busy when a load to it is pending and its data is not
  // arriving on the bypass this very cycle.
  function automatic logic f_busy(
    input logic [RW-1:0]   r,
    input logic [NREG-1:0] sb,
    input logic            ldv,
    input logic [RW-1:0]   ldr
  );
    return (r != REG_ZERO) && sb[r] && !(ldv && (ldr == r));
  endfunction

  // Operand resolution and issue/stall/flush decision for the ID instruction.
  always_comb begin
    w_rs1_res  = f_resolve(id_rs1, id_use_rs1, rf_rs1data, fwd_we, fwd_rd, fwd_data,
                           ld_done, ld_rd, ld_data);
    w_rs2_res  = f_resolve(id_rs2, id_use_rs2, rf_rs2data, fwd_we, fwd_rd, fwd_data,
                           ld_done, ld_rd, ld_data);
    w_haz1     = id_use_rs1 && f_busy(id_rs1, r_sb, ld_done, ld_rd);
    w_haz2     = id_use_rs2 && f_busy(id_rs2, r_sb, ld_done, ld_rd);
    w_waw      = id_regwrite && f_busy(id_rd, r_sb, ld_done, ld_rd);
    w_ldfull   = id_is_load && (r_cnt == CNT_MAX) && !ld_done;
    w_stall    = id_valid && (w_haz1 || w_haz2 || w_waw || w_ldfull);
    w_flush    = redirect || (r_flush_cnt != FLUSH_ZERO);
    w_issue    = id_valid && !w_stall && !w_flush;
    w_ld_issue = w_issue && id_is_load;
  end

  // Next scoreboard: clear the returning load first so a same-cycle set wins.
  always_comb begin
    w_sb_next = r_sb;
    if (ld_done) begin
      w_sb_next[ld_rd] = 1'b0;
    end else begin
      w_sb_next = r_sb;
    end
    if (w_ld_issue && (id_rd != REG_ZERO)) begin
      w_sb_next[id_rd] = 1'b1;
    end else begin
      w_sb_next = w_sb_next;
    end
  end

  // Scoreboard, outstanding-load count and sticky spurious-return error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb     <= {NREG{1'b0}};
      r_cnt    <= CNT_ZERO;
      r_ld_err <= 1'b0;
    end else begin
      r_sb <= w_sb_next;
      case ({w_ld_issue, ld_done})
        2'b10: r_cnt <= r_cnt + CNT_ONE;
        2'b01: begin
          if (r_cnt == CNT_ZERO) begin
            r_ld_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Flush counter: reload on every redirect, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_cnt <= FLUSH_ZERO;
    end else if (redirect) begin
      r_flush_cnt <= FLUSH_RELOAD;
    end else if (r_flush_cnt != FLUSH_ZERO) begin
      r_flush_cnt <= r_flush_cnt - FLUSH_ONE;
    end else begin
      r_flush_cnt <= r_flush_cnt;
    end
  end

  // Saturating count of cycles spent holding the PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'h0000_0000;
    end else if (hold_pc && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'h0000_0001;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign rs1_sel     = w_rs1_res[SELW+XLEN-1 -: SELW];
  assign rs1_fwd     = w_rs1_res[XLEN-1:0];
  assign rs2_sel     = w_rs2_res[SELW+XLEN-1 -: SELW];
  assign rs2_fwd     = w_rs2_res[XLEN-1:0];
  assign flush       = w_flush;
  assign hold_pc     = w_stall && !w_flush;
  assign id_issue    = w_issue;
  assign sb_pending  = r_sb;
  assign ld_err      = r_ld_err;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus random traffic.
// Each driven cycle pushes the reference model's expected outputs into a
// queue; a monitor on the falling edge pops and compares.
module tb_pipe_hazard_ctrl;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NF   = 2;
  localparam int FD   = 2;
  localparam int ML   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load;
  logic [4:0]  id_rs1, id_rs2, id_rd, ld_rd;
  logic [31:0] rf_rs1data, rf_rs2data, ld_data;
  logic [1:0]  fwd_we;
  logic [9:0]  fwd_rd;
  logic [63:0] fwd_data;
  logic        ld_done, redirect;
  logic        id_issue, hold_pc, flush, ld_err;
  logic [31:0] rs1_fwd, rs2_fwd, sb_pending, stall_count;
  logic [3:0]  rs1_sel, rs2_sel;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.XLEN(XLEN), .NREG(NREG), .FWD_STAGES(NF),
                     .FLUSH_DEPTH(FD), .MAX_LOADS(ML)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .rf_rs1data(rf_rs1data), .rf_rs2data(rf_rs2data),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .ld_done(ld_done), .ld_rd(ld_rd), .ld_data(ld_data), .redirect(redirect),
    .id_issue(id_issue), .hold_pc(hold_pc), .flush(flush),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .sb_pending(sb_pending), .ld_err(ld_err), .stall_count(stall_count)
  );

  typedef struct packed {
    logic        issue;
    logic        hold;
    logic        flsh;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [31:0] sb;
    logic        err;
    logic [31:0] sc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  // Reference model state
  bit              m_pend[NREG];
  int              m_out;
  int              m_flush_left;
  bit              m_err;
  longint unsigned m_stalls;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic m_reset();
    for (int r = 0; r < NREG; r++) m_pend[r] = 1'b0;
    m_out = 0; m_flush_left = 0; m_err = 1'b0; m_stalls = 0;
  endtask

  function automatic bit m_busy(input logic [4:0] r);
    return (r != 5'd0) && m_pend[r] && !(ld_done && ld_rd == r);
  endfunction

  task automatic m_res(input logic [4:0] src, input logic use_s, input logic [31:0] rf,
                       output logic [31:0] d, output logic [3:0] s);
    int hit;
    hit = -1;
    d = rf;
    s = 4'b1000;
    if (use_s && src != 5'd0) begin
      for (int k = NF - 1; k >= 0; k--)
        if (fwd_we[k] && fwd_rd[k*5 +: 5] == src) hit = k;
      if (hit >= 0) begin
        d = fwd_data[hit*32 +: 32];
        s = 4'b0001 << hit;
      end else if (ld_done && ld_rd == src) begin
        d = ld_data;
        s = 4'b0100;
      end
    end
  endtask

  task automatic m_push();
    exp_t e;
    bit stall, fl, ld;
    m_res(id_rs1, id_use_rs1, rf_rs1data, e.r1, e.s1);
    m_res(id_rs2, id_use_rs2, rf_rs2data, e.r2, e.s2);
    stall = id_valid && ((id_use_rs1 && m_busy(id_rs1)) || (id_use_rs2 && m_busy(id_rs2)) ||
                         (id_regwrite && m_busy(id_rd)) ||
                         (id_is_load && m_out == ML && !ld_done));
    fl      = redirect || m_flush_left > 0;
    e.flsh  = fl;
    e.hold  = stall && !fl;
    e.issue = id_valid && !stall && !fl;
    for (int r = 0; r < NREG; r++) e.sb[r] = m_pend[r];
    e.err = m_err;
    e.sc  = m_stalls[31:0];
    q.push_back(e);
    if (rst) begin
      m_reset();
    end else begin
      ld = e.issue && id_is_load;
      if (ld && !ld_done) m_out++;
      else if (!ld && ld_done) begin
        if (m_out == 0) m_err = 1'b1;
        else m_out--;
      end
      if (ld_done) m_pend[ld_rd] = 1'b0;
      if (ld && id_rd != 5'd0) m_pend[id_rd] = 1'b1;
      if (redirect) m_flush_left = FD - 1;
      else if (m_flush_left > 0) m_flush_left--;
      if (e.hold && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    end
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      cmp("issue", {31'd0, id_issue}, {31'd0, mon_e.issue});
      cmp("hold_pc", {31'd0, hold_pc}, {31'd0, mon_e.hold});
      cmp("flush", {31'd0, flush}, {31'd0, mon_e.flsh});
      cmp("rs1_fwd", rs1_fwd, mon_e.r1);
      cmp("rs2_fwd", rs2_fwd, mon_e.r2);
      cmp("rs1_sel", {28'd0, rs1_sel}, {28'd0, mon_e.s1});
      cmp("rs2_sel", {28'd0, rs2_sel}, {28'd0, mon_e.s2});
      cmp("sb_pending", sb_pending, mon_e.sb);
      cmp("ld_err", {31'd0, ld_err}, {31'd0, mon_e.err});
      cmp("stall_count", stall_count, mon_e.sc);
    end
  end

  task automatic idle();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rd = 5'd0; id_regwrite = 1'b0; id_is_load = 1'b0;
    rf_rs1data = 32'h0; rf_rs2data = 32'h0; fwd_we = 2'b00; fwd_rd = 10'd0;
    fwd_data = 64'h0; ld_done = 1'b0; ld_rd = 5'd0; ld_data = 32'h0; redirect = 1'b0;
  endtask

  task automatic go();
    m_push();
    @(negedge clk);
    #1;
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; go(); nx(); rst = 1'b0;
  endtask

  task automatic issue_load(input logic [4:0] r);
    idle(); id_valid = 1'b1; id_is_load = 1'b1; id_regwrite = 1'b1; id_rd = r;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    nx(); nx();
    m_reset();
    rst = 1'b0;
    idle(); go();
    cmp("rst_sb", sb_pending, 32'h0);
    cmp("rst_err", {31'd0, ld_err}, 32'd0);
    cmp("rst_stalls", stall_count, 32'd0);
    cmp("idle_flush", {31'd0, flush}, 32'd0);
    nx();

    // 1: youngest forwarding stage wins
    idle(); id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    id_rd = 5'd3; id_regwrite = 1'b1; rf_rs1data = 32'h11; rf_rs2data = 32'h22;
    fwd_we = 2'b11; fwd_rd = {5'd1, 5'd1}; fwd_data = {32'h77, 32'h55};
    go();
    cmp("t1_rs1", rs1_fwd, 32'h55);
    cmp("t1_sel1", {28'd0, rs1_sel}, 32'h1);
    cmp("t1_rs2", rs2_fwd, 32'h22);
    cmp("t1_sel2", {28'd0, rs2_sel}, 32'h8);
    cmp("t1_issue", {31'd0, id_issue}, 32'd1);
    nx();

    // 2: load-use stall, then load-return bypass
    issue_load(5'd5); go(); cmp("t2_lw", {31'd0, id_issue}, 32'd1); nx();
    for (int i = 0; i < 3; i++) begin
      idle(); id_valid = 1'b1; id_use_rs1 = 1'b1; id_rs1 = 5'd5; id_rd = 5'd6; id_regwrite = 1'b1;
      go();
      cmp("t2_hold", {31'd0, hold_pc}, 32'd1);
      cmp("t2_noissue", {31'd0, id_issue}, 32'd0);
      cmp("t2_pend5", {31'd0, sb_pending[5]}, 32'd1);
      nx();
    end
    ld_done = 1'b1; ld_rd = 5'd5; ld_data = 32'hDEAD; go();
    cmp("t2_stalls", stall_count, 32'd3);
    cmp("t2_issue", {31'd0, id_issue}, 32'd1);
    cmp("t2_bypass", rs1_fwd, 32'hDEAD);
    cmp("t2_sel", {28'd0, rs1_sel}, 32'h4);
    nx();
    idle(); go(); cmp("t2_clear5", {31'd0, sb_pending[5]}, 32'd0); nx();

    // 3: outstanding-load limit
    do_reset();
    for (int r = 6; r <= 9; r++) begin
      issue_load(5'(r)); go(); cmp("t3_ld", {31'd0, id_issue}, 32'd1); nx();
    end
    issue_load(5'd10); go(); cmp("t3_full", {31'd0, hold_pc}, 32'd1); nx();
    ld_done = 1'b1; ld_rd = 5'd6; go(); cmp("t3_swap", {31'd0, id_issue}, 32'd1); nx();
    issue_load(5'd11); go(); cmp("t3_still_full", {31'd0, hold_pc}, 32'd1); nx();

    // 4: flush overrides stall; second redirect extends the flush
    do_reset();
    issue_load(5'd4); go(); nx();
    idle(); id_valid = 1'b1; id_use_rs1 = 1'b1; id_rs1 = 5'd4; id_rd = 5'd7; id_regwrite = 1'b1;
    redirect = 1'b1; go();
    cmp("t4_f1", {31'd0, flush}, 32'd1);
    cmp("t4_h1", {31'd0, hold_pc}, 32'd0);
    cmp("t4_i1", {31'd0, id_issue}, 32'd0);
    nx();
    redirect = 1'b0; go();
    cmp("t4_f2", {31'd0, flush}, 32'd1);
    cmp("t4_h2", {31'd0, hold_pc}, 32'd0);
    nx();
    go(); cmp("t4_f3", {31'd0, flush}, 32'd0); cmp("t4_h3", {31'd0, hold_pc}, 32'd1); nx();
    redirect = 1'b1; go(); nx();
    go(); nx();
    redirect = 1'b0; go(); cmp("t4_ext", {31'd0, flush}, 32'd1); nx();
    go(); cmp("t4_end", {31'd0, flush}, 32'd0); nx();

    // 5: spurious load return sets sticky error; reset clears everything
    do_reset();
    issue_load(5'd2); go(); nx();
    for (int i = 0; i < 2; i++) begin
      idle(); id_valid = 1'b1; id_use_rs1 = 1'b1; id_rs1 = 5'd2; go(); nx();
    end
    idle(); ld_done = 1'b1; ld_rd = 5'd2; go(); nx();
    idle(); ld_done = 1'b1; ld_rd = 5'd2; go(); nx();
    idle(); go();
    cmp("t5_err", {31'd0, ld_err}, 32'd1);
    cmp("t5_stalls", stall_count, 32'd2);
    nx();
    issue_load(5'd9); go(); nx();
    idle(); go(); cmp("t5_sticky", {31'd0, ld_err}, 32'd1); nx();
    rst = 1'b1; go(); nx(); rst = 1'b0;
    idle(); go();
    cmp("t5_rst_err", {31'd0, ld_err}, 32'd0);
    cmp("t5_rst_stalls", stall_count, 32'd0);
    cmp("t5_rst_sb", sb_pending, 32'h0);
    nx();

    // 6: WAW stall, then same-cycle set/clear where the set wins
    do_reset();
    issue_load(5'd4); go(); nx();
    idle(); id_valid = 1'b1; id_regwrite = 1'b1; id_rd = 5'd4; go();
    cmp("t6_waw", {31'd0, hold_pc}, 32'd1);
    nx();
    issue_load(5'd4); ld_done = 1'b1; ld_rd = 5'd4; go();
    cmp("t6_issue", {31'd0, id_issue}, 32'd1);
    nx();
    idle(); go(); cmp("t6_setwins", {31'd0, sb_pending[4]}, 32'd1); nx();

    // Random traffic on a small register window to provoke hazards
    do_reset();
    repeat (3000) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_rd       = 5'($urandom_range(0, 7));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      id_regwrite = 1'($urandom_range(0, 1));
      id_is_load  = ($urandom_range(0, 2) == 0);
      rf_rs1data  = $urandom;
      rf_rs2data  = $urandom;
      fwd_we      = 2'($urandom_range(0, 3));
      fwd_rd      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_data    = {$urandom, $urandom};
      ld_done     = ($urandom_range(0, 3) == 0);
      ld_rd       = 5'($urandom_range(0, 7));
      ld_data     = $urandom;
      redirect    = ($urandom_range(0, 9) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      go();
      nx();
    end
    rst = 1'b0;
    idle();

    repeat (4) @(negedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
